muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: unsigned 16x16 multiply / 16/16 divide, one bit per cycle, writes the 32-bit result as two register-file writes.
// Latency: 18 edges from start to IDLE with wb_ready high (16 CALC + 2 writeback); divide by zero skips CALC (2 edges).
// Backpressure: wb_ready low holds the pending write (wr_dest/wr_data stable) indefinitely; start is ignored while busy.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, op, dest    request (op 0 = mul, 1 = div), destination for low half / quotient
//   a, b               operands (unsigned)
//   wb_ready           register-file write port granted this cycle
//   busy               high outside IDLE
//   wr_en/wr_dest/wr_data  write request; the second write always targets R15
//   div_by_zero        high in both writeback states of a divide by zero
//   done               pulse when the final (R15) write is accepted
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [3:0]  dest,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        wb_ready,
  output logic        busy,
  output logic        wr_en,
  output logic [3:0]  wr_dest,
  output logic [15:0] wr_data,
  output logic        div_by_zero,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WB_LO = 2'd2,
    WB_HI = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        op_q, op_d;
  logic [3:0]  dest_q, dest_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] b_q, b_d;
  logic        dbz_q, dbz_d;
  // acc holds {high half, low half}. Multiply: {partial product, remaining multiplier bits}.
  // Divide: {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [31:0] acc_q, acc_d;

  logic [16:0] mul_sum;
  logic [16:0] div_shift;
  logic [16:0] div_diff;
  logic        div_ge;

  always_comb begin
    mul_sum   = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, b_q} : 17'd0);
    div_shift = {acc_q[31:16], acc_q[15]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift - {1'b0, b_q};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    dbz_d   = dbz_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          dest_d = dest;
          b_d    = b;
          cnt_d  = 4'd0;
          if (op && (b == 16'd0)) begin
            // Result is known immediately: quotient all ones, remainder = dividend.
            acc_d   = {a, 16'hFFFF};
            dbz_d   = 1'b1;
            state_d = WB_LO;
          end else begin
            acc_d   = {16'h0000, a};
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q) begin
          // Restoring step; when the trial subtract fails the shifted value is < b, so it fits 16 bits.
          if (div_ge) acc_d = {div_diff[15:0], acc_q[14:0], 1'b1};
          else        acc_d = {div_shift[15:0], acc_q[14:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[15:1]};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = WB_LO;
      end
      WB_LO: begin
        if (wb_ready) state_d = WB_HI;
      end
      WB_HI: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      dest_q  <= 4'd0;
      cnt_q   <= 4'd0;
      b_q     <= 16'd0;
      dbz_q   <= 1'b0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      dbz_q   <= dbz_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    wr_en       = 1'b0;
    wr_dest     = 4'd0;
    wr_data     = 16'd0;
    div_by_zero = 1'b0;
    done        = 1'b0;
    case (state_q)
      WB_LO: begin
        wr_en       = 1'b1;
        wr_dest     = dest_q;
        wr_data     = acc_q[15:0];
        div_by_zero = dbz_q;
      end
      WB_HI: begin
        wr_en       = 1'b1;
        wr_dest     = 4'd15;
        wr_data     = acc_q[31:16];
        div_by_zero = dbz_q;
        done        = wb_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [3:0]  dest;
  logic [15:0] a;
  logic [15:0] b;
  logic        wb_ready;
  logic        busy;
  logic        wr_en;
  logic [3:0]  wr_dest;
  logic [15:0] wr_data;
  logic        div_by_zero;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .dest        (dest),
    .a           (a),
    .b           (b),
    .wb_ready    (wb_ready),
    .busy        (busy),
    .wr_en       (wr_en),
    .wr_dest     (wr_dest),
    .wr_data     (wr_data),
    .div_by_zero (div_by_zero),
    .done        (done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until wr_en rises (bounded).
  task automatic wait_wr(output int n);
    n = 0;
    while (!wr_en && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic o, input logic [3:0] d, input logic [15:0] x, input logic [15:0] y);
    op = o; dest = d; a = x; b = y; start = 1'b1;
    tick();               // E0
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; op = ~o; dest = 4'd9;   // changes after acceptance must not matter
  endtask

  // Full operation with wb_ready held high.
  task automatic run_op(input string nm, input logic o, input logic [3:0] d, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] lo, input logic [15:0] hi,
                        input logic dbz, input int lat);
    int n;
    wb_ready = 1'b1;
    issue(o, d, x, y);
    check_val({nm, "_busy"}, busy, 1);
    wait_wr(n);
    check_val({nm, "_lat"}, n, lat);
    check_val({nm, "_lo_dest"}, wr_dest, d);
    check_val({nm, "_lo_data"}, wr_data, lo);
    check_val({nm, "_lo_dbz"}, div_by_zero, dbz);
    check_val({nm, "_lo_done"}, done, 0);
    tick();
    check_val({nm, "_hi_en"}, wr_en, 1);
    check_val({nm, "_hi_dest"}, wr_dest, 15);
    check_val({nm, "_hi_data"}, wr_data, hi);
    check_val({nm, "_hi_dbz"}, div_by_zero, dbz);
    check_val({nm, "_hi_done"}, done, 1);
    tick();
    check_val({nm, "_idle_busy"}, busy, 0);
    check_val({nm, "_idle_out"}, {wr_en, wr_dest, wr_data, div_by_zero, done}, 0);
  endtask

  initial begin
    int n;
    int stray;
    rst = 1'b1; start = 1'b0; op = 1'b0; dest = 4'd0; a = 16'd0; b = 16'd0; wb_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_val("reset_busy", busy, 0);
    check_val("reset_out", {wr_en, wr_dest, wr_data, div_by_zero, done}, 0);

    // 0x1234 * 0x5678 = 0x06260060
    run_op("mul1", 1'b0, 4'd3, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 1'b0, 16);
    // 80 / 7 = 11 r 3
    run_op("div1", 1'b1, 4'd5, 16'h0050, 16'h0007, 16'h000B, 16'h0003, 1'b0, 16);
    // divide by zero: no CALC, write right after E0
    run_op("dbz", 1'b1, 4'd2, 16'h00FF, 16'h0000, 16'hFFFF, 16'h00FF, 1'b1, 0);
    // dest 15: 0x100 * 0x100 = 0x00010000
    run_op("d15", 1'b0, 4'd15, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b0, 16);

    // 0xFFFF*0xFFFF = 0xFFFE0001 with stalls and a start during CALC
    wb_ready = 1'b0;
    issue(1'b0, 4'd7, 16'hFFFF, 16'hFFFF);
    tick(); tick();
    op = 1'b0; a = 16'd2; b = 16'd3; dest = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_wr(n);
    check_val("stall_lat", n, 13);
    for (int i = 0; i < 3; i++) begin
      check_val("stall_lo_dest", wr_dest, 7);
      check_val("stall_lo_data", wr_data, 16'h0001);
      check_val("stall_lo_done", done, 0);
      tick();
    end
    check_val("stall_lo_held", wr_dest, 7);
    wb_ready = 1'b1;
    #1;
    check_val("stall_lo_acc_done", done, 0);
    tick();
    wb_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val("stall_hi_dest", wr_dest, 15);
      check_val("stall_hi_data", wr_data, 16'hFFFE);
      check_val("stall_hi_done", done, 0);
      tick();
    end
    wb_ready = 1'b1;
    #1;
    check_val("stall_hi_data2", wr_data, 16'hFFFE);
    check_val("stall_hi_done2", done, 1);
    tick();
    check_val("stall_idle", busy, 0);
    // the ignored start must not have launched anything
    tick();
    check_val("ignored_start", {busy, wr_en}, 0);

    // reset at iteration count 8
    issue(1'b0, 4'd4, 16'h1234, 16'h5678);
    for (int i = 0; i < 8; i++) tick();
    check_val("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_out", {wr_en, wr_dest, wr_data, div_by_zero, done}, 0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_en) stray++;
    end
    check_val("rst_no_write", stray, 0);
    run_op("post_rst", 1'b0, 4'd6, 16'd2, 16'd3, 16'h0006, 16'h0000, 1'b0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
